queue_drain: RTL and testbench

QUEUE_DRAIN -- requirements
Module: queue_drain

---
 rtl/queue_pkg.sv | 17 +
 rtl/drain_buf.sv | 52 +++++
 rtl/queue_drain.sv | 88 ++++++++
 tb/tb_queue_drain.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared types and constants for the queue drain block.
package queue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } drain_state_t;

  localparam int unsigned              DRAIN_CNT_W   = 16;
  localparam logic [DRAIN_CNT_W-1:0]   DRAIN_CNT_MAX = 16'hFFFF;

  function automatic logic [DRAIN_CNT_W-1:0] sat_inc(input logic [DRAIN_CNT_W-1:0] v);
    return (v == DRAIN_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/drain_buf.sv
// DEPTH-entry register FIFO holding captured words until the downstream accepts them.
module drain_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_q + 1'b1;
      if (do_pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[tail_q] <= push_data;
  end

  // Storage is not reset, so mask the head while empty.
  assign head_data = (count_q != '0) ? mem[head_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/queue_drain.sv
// Drains an upstream queue into a small output buffer with credit-based dequeue,
// flush, miss detection and a saturating handshake counter.
module queue_drain
  import queue_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   q_empty,
  output logic                   q_deq,
  input  logic                   q_ready,
  input  logic [WIDTH-1:0]       q_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [DRAIN_CNT_W-1:0] drained_cnt,
  output logic                   err_miss
);

  localparam int unsigned CNT_W = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;

  drain_state_t           state_q, state_d;
  logic                   inflight_q;
  logic                   err_miss_q;
  logic [DRAIN_CNT_W-1:0] drained_q;
  logic [CNT_W-1:0]       count;
  logic [CNT_W:0]         pending;
  logic                   pop, flushing, push;

  assign pop      = m_valid && m_ready;
  assign flushing = flush || (state_q == FLUSH);
  assign push     = inflight_q && q_ready && !flushing;

  // Words already owned by this block after this cycle; a pop frees a slot immediately.
  assign pending = {1'b0, count} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign q_deq   = (state_q == RUN) && !flush && !q_empty && (pending < (CNT_W + 1)'(DEPTH));

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE:    if (en) state_d = RUN;
        RUN:     if (!en) state_d = IDLE;
        FLUSH:   if (!inflight_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      err_miss_q <= 1'b0;
      drained_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= q_deq;
      err_miss_q <= err_miss_q | (inflight_q & ~q_ready);
      if (pop) drained_q <= sat_inc(drained_q);
    end
  end

  drain_buf #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flushing),
    .push     (push),
    .push_data(q_data),
    .pop      (pop),
    .count    (count),
    .head_data(m_data)
  );

  assign m_valid     = (count != '0);
  assign drained_cnt = drained_q;
  assign err_miss    = err_miss_q;

endmodule

// File: tb/tb_queue_drain.sv
// Scoreboard bench for queue_drain: an upstream queue model feeds words and
// delivered words are popped from an expected queue and compared in order.
module tb_queue_drain;
  import queue_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic             q_empty = 1'b1;
  logic             q_ready = 1'b0;
  logic [WIDTH-1:0] q_data = '0;
  logic             m_ready = 1'b0;
  logic             q_deq;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [15:0]      drained_cnt;
  logic             err_miss;

  queue_drain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .q_empty    (q_empty),
    .q_deq      (q_deq),
    .q_ready    (q_ready),
    .q_data     (q_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .drained_cnt(drained_cnt),
    .err_miss   (err_miss)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               passed = 0;
  int               delivered = 0;
  logic [15:0]      pops_model = '0;
  bit               miss_mode = 1'b0;
  logic [WIDTH-1:0] up_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             s_deq, s_mv;
  logic [WIDTH-1:0] s_md;

  task automatic load(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) up_q.push_back(base + WIDTH'(i));
    q_empty = (up_q.size() == 0);
  endtask

  // One clock: sample at negedge, score handshakes, then play upstream after the edge.
  task automatic cycle();
    logic [WIDTH-1:0] word, want;
    logic             s_qe;
    @(negedge clk);
    s_deq = q_deq;
    s_mv  = m_valid;
    s_md  = m_data;
    s_qe  = q_empty;
    checks++;
    if (s_deq && s_qe) $display("FAIL deq_when_empty q_deq=%b required 0", s_deq);
    else passed++;
    if (s_mv && m_ready) begin
      delivered++;
      if (pops_model != 16'hFFFF) pops_model = pops_model + 16'd1;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_word got %h required none", s_md);
      end else begin
        want = exp_q.pop_front();
        if (s_md !== want) $display("FAIL data_order got %h required %h", s_md, want);
        else passed++;
      end
    end
    @(posedge clk);
    #1;
    q_ready = 1'b0;
    if (s_deq) begin
      word = (up_q.size() != 0) ? up_q.pop_front() : '0;
      q_data  = word;
      q_ready = !miss_mode;
      if (!miss_mode) exp_q.push_back(word);
    end
    q_empty = (up_q.size() == 0);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b required 0", m_valid); else passed++;
    checks++; if (q_deq !== 1'b0) $display("FAIL rst_q_deq got %b required 0", q_deq); else passed++;
    checks++; if (m_data !== '0) $display("FAIL rst_m_data got %h required 0", m_data); else passed++;
    checks++; if (drained_cnt !== 16'd0) $display("FAIL rst_drained got %h required 0", drained_cnt); else passed++;
    checks++; if (err_miss !== 1'b0) $display("FAIL rst_err_miss got %b required 0", err_miss); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (dut.state_q !== IDLE) $display("FAIL rst_state got %0d required IDLE", dut.state_q); else passed++;
  endtask

  task automatic test_streaming();
    logic deq_tr[16], mv_tr[16];
    int   first_deq, first_mv, deq_run, mv_run, deq_tot, d0;
    first_deq = -1; first_mv = -1; deq_run = 0; mv_run = 0; deq_tot = 0;
    d0 = delivered;
    load(32'hA0, 4);
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      deq_tr[i] = s_deq; mv_tr[i] = s_mv;
      if (s_deq) deq_tot++;
      if (s_deq && first_deq < 0) first_deq = i;
      if (s_mv && first_mv < 0) first_mv = i;
    end
    en = 1'b0;
    if (first_deq >= 0) for (int i = first_deq; i < 16 && deq_tr[i]; i++) deq_run++;
    if (first_mv >= 0) for (int i = first_mv; i < 16 && mv_tr[i]; i++) mv_run++;
    checks++; if (deq_tot != 4 || deq_run != 4) $display("FAIL stream_deq got total %0d run %0d required 4 4", deq_tot, deq_run); else passed++;
    checks++; if (mv_run != 4) $display("FAIL stream_valid_run got %0d required 4", mv_run); else passed++;
    // q_ready returns one cycle after q_deq; m_valid follows one cycle after that
    checks++; if (first_deq < 0 || first_mv != first_deq + 2) $display("FAIL stream_latency got mv@%0d deq@%0d required mv=deq+2", first_mv, first_deq); else passed++;
    checks++; if (delivered - d0 != 4) $display("FAIL stream_delivered got %0d required 4", delivered - d0); else passed++;
    checks++; if (drained_cnt !== pops_model) $display("FAIL stream_drained got %h required %h", drained_cnt, pops_model); else passed++;
  endtask

  task automatic test_backpressure();
    int deq_tot, d0, guard;
    deq_tot = 0; d0 = delivered;
    load(32'hA0, 5);
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_deq) deq_tot++;
      if (s_mv) begin
        checks++; if (s_md !== 32'hA0) $display("FAIL bp_hold got %h required a0", s_md); else passed++;
      end
    end
    checks++; if (deq_tot != 2) $display("FAIL bp_deq_pulses got %0d required 2", deq_tot); else passed++;
    checks++; if (dut.count !== 2'd2) $display("FAIL bp_count got %0d required 2", dut.count); else passed++;
    checks++; if (m_data !== 32'hA0) $display("FAIL bp_head got %h required a0", m_data); else passed++;
    m_ready = 1'b1;
    guard = 0;
    while ((delivered - d0 < 5) && guard < 30) begin cycle(); guard++; end
    en = 1'b0;
    checks++; if (delivered - d0 != 5) $display("FAIL bp_delivered got %0d required 5", delivered - d0); else passed++;
    checks++; if (exp_q.size() != 0) $display("FAIL bp_leftover got %0d required 0", exp_q.size()); else passed++;
  endtask

  task automatic test_miss();
    int guard;
    miss_mode = 1'b1;
    load(32'hC0, 1);
    en = 1'b1; m_ready = 1'b1;
    guard = 0; s_deq = 1'b0;
    while (!s_deq && guard < 6) begin cycle(); guard++; end
    en = 1'b0;
    checks++; if (!s_deq) $display("FAIL miss_no_deq got %b required 1", s_deq); else passed++;
    checks++; if (err_miss !== 1'b0) $display("FAIL miss_early got %b required 0", err_miss); else passed++;
    cycle();
    checks++; if (err_miss !== 1'b1) $display("FAIL miss_flag got %b required 1", err_miss); else passed++;
    checks++; if (dut.count !== 2'd0) $display("FAIL miss_count got %0d required 0", dut.count); else passed++;
    cycle();
    checks++; if (m_valid !== 1'b0) $display("FAIL miss_valid got %b required 0", m_valid); else passed++;
    checks++; if (err_miss !== 1'b1) $display("FAIL miss_sticky got %b required 1", err_miss); else passed++;
    miss_mode = 1'b0;
  endtask

  task automatic test_flush();
    int guard, deq_tot, d0;
    load(32'hD0, 4);
    en = 1'b1; m_ready = 1'b0;
    guard = 0;
    while (!(dut.count == 2'd1 && dut.inflight_q) && guard < 10) begin cycle(); guard++; end
    checks++; if (guard >= 10) $display("FAIL flush_setup got count %0d required 1 plus in-flight", dut.count); else passed++;
    // Buffered D0 and the in-flight D1 are both thrown away
    flush = 1'b1; en = 1'b0;
    exp_q.delete();
    cycle();
    flush = 1'b0;
    checks++; if (s_deq !== 1'b0) $display("FAIL flush_deq got %b required 0", s_deq); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL flush_valid got %b required 0", m_valid); else passed++;
    checks++; if (dut.state_q !== FLUSH) $display("FAIL flush_state got %0d required FLUSH", dut.state_q); else passed++;
    cycle();
    checks++; if (dut.state_q !== IDLE) $display("FAIL flush_idle got %0d required IDLE", dut.state_q); else passed++;
    deq_tot = 0;
    for (int i = 0; i < 3; i++) begin cycle(); if (s_deq) deq_tot++; end
    checks++; if (deq_tot != 0) $display("FAIL flush_quiet got %0d required 0", deq_tot); else passed++;
    d0 = delivered;
    en = 1'b1; m_ready = 1'b1;
    guard = 0;
    while ((delivered - d0 < 2) && guard < 20) begin cycle(); guard++; end
    en = 1'b0;
    checks++; if (delivered - d0 != 2) $display("FAIL flush_resume got %0d required 2", delivered - d0); else passed++;
  endtask

  task automatic test_async_reset();
    int guard, n_left, d0;
    load(32'hE0, 6);
    en = 1'b1; m_ready = 1'b1;
    guard = 0; s_mv = 1'b0;
    while (!s_mv && guard < 8) begin cycle(); guard++; end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL ar_valid got %b required 0", m_valid); else passed++;
    checks++; if (q_deq !== 1'b0) $display("FAIL ar_deq got %b required 0", q_deq); else passed++;
    checks++; if (drained_cnt !== 16'd0) $display("FAIL ar_drained got %h required 0", drained_cnt); else passed++;
    checks++; if (err_miss !== 1'b0) $display("FAIL ar_err got %b required 0", err_miss); else passed++;
    pops_model = '0;
    exp_q.delete();
    q_ready = 1'b0;
    n_left = up_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (q_deq !== 1'b0) $display("FAIL ar_first_edge got %b required 0", q_deq); else passed++;
    d0 = delivered;
    guard = 0;
    while ((delivered - d0 < n_left) && guard < 30) begin cycle(); guard++; end
    en = 1'b0;
    checks++; if (delivered - d0 != n_left) $display("FAIL ar_delivered got %0d required %0d", delivered - d0, n_left); else passed++;
    checks++; if (drained_cnt !== pops_model) $display("FAIL ar_count got %h required %h", drained_cnt, pops_model); else passed++;
  endtask

  task automatic test_saturation();
    int guard, d0;
    force dut.drained_q = 16'hFFFE;
    #1;
    release dut.drained_q;
    pops_model = 16'hFFFE;
    checks++; if (drained_cnt !== pops_model) $display("FAIL sat_preload got %h required %h", drained_cnt, pops_model); else passed++;
    d0 = delivered;
    load(32'hF0, 3);
    en = 1'b1; m_ready = 1'b1;
    guard = 0;
    while ((delivered - d0 < 3) && guard < 20) begin
      cycle(); guard++;
      if (delivered - d0 >= 2) begin
        checks++; if (drained_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h required ffff", drained_cnt); else passed++;
      end
    end
    en = 1'b0;
    cycle();
    checks++; if (drained_cnt !== pops_model) $display("FAIL sat_final got %h required %h", drained_cnt, pops_model); else passed++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_miss();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
